// File: rtl/stage_mem.sv
// Memory-access stage of the RV32I pipeline: drives loads/stores over a Wishbone-style
// master port and hands one registered instruction per cycle to write-back.
module stage_mem #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        kill_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  input  logic [31:0] alu_d_i,
  input  logic [31:0] rs2_d_i,
  input  logic        e_illegal_inst_i,
  input  logic        e_inst_addr_mis_i,
  output logic        stall_o,
  output logic [31:0] dwbm_addr_o,
  output logic [31:0] dwbm_dat_o,
  output logic [3:0]  dwbm_sel_o,
  output logic        dwbm_we_o,
  output logic        dwbm_cyc_o,
  output logic        dwbm_stb_o,
  input  logic [31:0] dwbm_dat_i,
  input  logic        dwbm_ack_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_pc_o,
  output logic [31:0] wb_instruction_o,
  output logic [31:0] wb_alu_d_o,
  output logic [31:0] wb_mem_d_o,
  output logic [31:0] wb_mem_addr_o,
  output logic        wb_e_illegal_inst_o,
  output logic        wb_e_inst_addr_mis_o,
  output logic        wb_e_ld_addr_mis_o,
  output logic        wb_e_st_addr_mis_o,
  output logic        wb_e_ld_fault_o,
  output logic        wb_e_st_fault_o
);

  localparam int unsigned CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1);
  localparam bit TO_EN = (BUS_TIMEOUT != 0);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic {S_IDLE, S_BUS} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d, cyc_q, cyc_d, stb_q, stb_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_pc_q, wb_pc_d, wb_instr_q, wb_instr_d, wb_alu_q, wb_alu_d;
  logic [31:0] wb_mem_d_q, wb_mem_d_d, wb_mem_addr_q, wb_mem_addr_d;
  logic        ill_q, ill_d, imis_q, imis_d, ldmis_q, ldmis_d, stmis_q, stmis_d;
  logic        ldflt_q, ldflt_d, stflt_q, stflt_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_load, is_store, misaligned, accept, mem_req, timeout;
  logic [31:0] st_dat, ld_data;
  logic [3:0]  st_sel;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Instruction decode and request qualification
  always_comb begin
    opcode     = instruction_i[6:0];
    funct3     = instruction_i[14:12];
    is_load    = (opcode == OP_LOAD);
    is_store   = (opcode == OP_STORE);
    misaligned = ((funct3[1:0] == 2'b01) && alu_d_i[0]) ||
                 ((funct3[1:0] == 2'b10) && (alu_d_i[1:0] != 2'b00));
    accept     = valid_i & ~kill_i;
    mem_req    = accept & (is_load | is_store) & ~misaligned &
                 ~e_illegal_inst_i & ~e_inst_addr_mis_i;
    timeout    = TO_EN && (cnt_q == '0);
  end

  // Store lane replication and byte enables
  always_comb begin
    st_dat = rs2_d_i;
    st_sel = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_dat = {4{rs2_d_i[7:0]}};
        st_sel = 4'b0001 << alu_d_i[1:0];
      end
      2'b01: begin
        st_dat = {2{rs2_d_i[15:0]}};
        st_sel = alu_d_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_dat = rs2_d_i;
        st_sel = 4'b1111;
      end
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    ld_byte = dwbm_dat_i[7:0];
    case (alu_d_i[1:0])
      2'd0:    ld_byte = dwbm_dat_i[7:0];
      2'd1:    ld_byte = dwbm_dat_i[15:8];
      2'd2:    ld_byte = dwbm_dat_i[23:16];
      default: ld_byte = dwbm_dat_i[31:24];
    endcase
    ld_half = alu_d_i[1] ? dwbm_dat_i[31:16] : dwbm_dat_i[15:0];
    case (funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = dwbm_dat_i;
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = 32'h0;
    endcase
  end

  // Next-state, bus and write-back register logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    dat_d         = dat_q;
    sel_d         = sel_q;
    we_d          = we_q;
    cyc_d         = cyc_q;
    stb_d         = stb_q;
    wb_valid_d    = wb_valid_q;
    wb_pc_d       = wb_pc_q;
    wb_instr_d    = wb_instr_q;
    wb_alu_d      = wb_alu_q;
    wb_mem_d_d    = wb_mem_d_q;
    wb_mem_addr_d = wb_mem_addr_q;
    ill_d         = ill_q;
    imis_d        = imis_q;
    ldmis_d       = ldmis_q;
    stmis_d       = stmis_q;
    ldflt_d       = ldflt_q;
    stflt_d       = stflt_q;
    stall_o       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          stall_o    = 1'b1;
          state_d    = S_BUS;
          cnt_d      = CNT_LOAD;
          cyc_d      = 1'b1;
          stb_d      = 1'b1;
          we_d       = is_store;
          addr_d     = {alu_d_i[31:2], 2'b00};
          dat_d      = is_store ? st_dat : 32'h0;
          sel_d      = is_store ? st_sel : 4'b1111;
          wb_valid_d = 1'b0;
          wb_instr_d = NOP;
          ill_d      = 1'b0;
          imis_d     = 1'b0;
          ldmis_d    = 1'b0;
          stmis_d    = 1'b0;
          ldflt_d    = 1'b0;
          stflt_d    = 1'b0;
        end else begin
          wb_valid_d    = accept;
          wb_pc_d       = pc_i;
          wb_alu_d      = alu_d_i;
          wb_mem_addr_d = alu_d_i;
          wb_mem_d_d    = 32'h0;
          wb_instr_d    = accept ? instruction_i : NOP;
          ill_d         = accept & e_illegal_inst_i;
          imis_d        = accept & e_inst_addr_mis_i;
          ldmis_d       = accept & is_load & misaligned;
          stmis_d       = accept & is_store & misaligned;
          ldflt_d       = 1'b0;
          stflt_d       = 1'b0;
        end
      end
      S_BUS: begin
        // kill_i is deliberately not consulted: the bus cycle is already committed
        stall_o = ~(dwbm_ack_i | timeout);
        if (dwbm_ack_i | timeout) begin
          state_d       = S_IDLE;
          cyc_d         = 1'b0;
          stb_d         = 1'b0;
          wb_valid_d    = 1'b1;
          wb_pc_d       = pc_i;
          wb_instr_d    = instruction_i;
          wb_alu_d      = alu_d_i;
          wb_mem_addr_d = alu_d_i;
          wb_mem_d_d    = (dwbm_ack_i && is_load) ? ld_data : 32'h0;
          ill_d         = e_illegal_inst_i;
          imis_d        = e_inst_addr_mis_i;
          ldmis_d       = 1'b0;
          stmis_d       = 1'b0;
          ldflt_d       = ~dwbm_ack_i & is_load;
          stflt_d       = ~dwbm_ack_i & is_store;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      addr_q        <= 32'h0;
      dat_q         <= 32'h0;
      sel_q         <= 4'h0;
      we_q          <= 1'b0;
      cyc_q         <= 1'b0;
      stb_q         <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_pc_q       <= 32'h0;
      wb_instr_q    <= NOP;
      wb_alu_q      <= 32'h0;
      wb_mem_d_q    <= 32'h0;
      wb_mem_addr_q <= 32'h0;
      ill_q         <= 1'b0;
      imis_q        <= 1'b0;
      ldmis_q       <= 1'b0;
      stmis_q       <= 1'b0;
      ldflt_q       <= 1'b0;
      stflt_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      dat_q         <= dat_d;
      sel_q         <= sel_d;
      we_q          <= we_d;
      cyc_q         <= cyc_d;
      stb_q         <= stb_d;
      wb_valid_q    <= wb_valid_d;
      wb_pc_q       <= wb_pc_d;
      wb_instr_q    <= wb_instr_d;
      wb_alu_q      <= wb_alu_d;
      wb_mem_d_q    <= wb_mem_d_d;
      wb_mem_addr_q <= wb_mem_addr_d;
      ill_q         <= ill_d;
      imis_q        <= imis_d;
      ldmis_q       <= ldmis_d;
      stmis_q       <= stmis_d;
      ldflt_q       <= ldflt_d;
      stflt_q       <= stflt_d;
    end
  end

  assign dwbm_addr_o          = addr_q;
  assign dwbm_dat_o           = dat_q;
  assign dwbm_sel_o           = sel_q;
  assign dwbm_we_o            = we_q;
  assign dwbm_cyc_o           = cyc_q;
  assign dwbm_stb_o           = stb_q;
  assign wb_valid_o           = wb_valid_q;
  assign wb_pc_o              = wb_pc_q;
  assign wb_instruction_o     = wb_instr_q;
  assign wb_alu_d_o           = wb_alu_q;
  assign wb_mem_d_o           = wb_mem_d_q;
  assign wb_mem_addr_o        = wb_mem_addr_q;
  assign wb_e_illegal_inst_o  = ill_q;
  assign wb_e_inst_addr_mis_o = imis_q;
  assign wb_e_ld_addr_mis_o   = ldmis_q;
  assign wb_e_st_addr_mis_o   = stmis_q;
  assign wb_e_ld_fault_o      = ldflt_q;
  assign wb_e_st_fault_o      = stflt_q;

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem: expected write-back records are queued at issue
// and compared when the stage presents them.
module tb_stage_mem;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;

  logic        clk, rst;
  logic        valid_i, kill_i, e_ill, e_imis;
  logic [31:0] pc_i, instr_i, alu_i, rs2_i;
  logic        stall_o;
  logic [31:0] dwbm_addr_o, dwbm_dat_o, dwbm_dat_i;
  logic [3:0]  dwbm_sel_o;
  logic        dwbm_we_o, dwbm_cyc_o, dwbm_stb_o, dwbm_ack_i;
  logic        wb_valid_o;
  logic [31:0] wb_pc_o, wb_instruction_o, wb_alu_d_o, wb_mem_d_o, wb_mem_addr_o;
  logic        wb_ill, wb_imis, wb_ldmis, wb_stmis, wb_ldflt, wb_stflt;

  stage_mem #(.BUS_TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .kill_i(kill_i),
    .pc_i(pc_i), .instruction_i(instr_i), .alu_d_i(alu_i), .rs2_d_i(rs2_i),
    .e_illegal_inst_i(e_ill), .e_inst_addr_mis_i(e_imis), .stall_o(stall_o),
    .dwbm_addr_o(dwbm_addr_o), .dwbm_dat_o(dwbm_dat_o), .dwbm_sel_o(dwbm_sel_o),
    .dwbm_we_o(dwbm_we_o), .dwbm_cyc_o(dwbm_cyc_o), .dwbm_stb_o(dwbm_stb_o),
    .dwbm_dat_i(dwbm_dat_i), .dwbm_ack_i(dwbm_ack_i), .wb_valid_o(wb_valid_o),
    .wb_pc_o(wb_pc_o), .wb_instruction_o(wb_instruction_o), .wb_alu_d_o(wb_alu_d_o),
    .wb_mem_d_o(wb_mem_d_o), .wb_mem_addr_o(wb_mem_addr_o),
    .wb_e_illegal_inst_o(wb_ill), .wb_e_inst_addr_mis_o(wb_imis),
    .wb_e_ld_addr_mis_o(wb_ldmis), .wb_e_st_addr_mis_o(wb_stmis),
    .wb_e_ld_fault_o(wb_ldflt), .wb_e_st_fault_o(wb_stflt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // flags order: illegal, inst_mis, ld_mis, st_mis, ld_fault, st_fault
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] mem_d;
    logic [31:0] mem_addr;
    logic [5:0]  flags;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {17'h0, f3, 5'd5, op};
  endfunction

  function automatic wb_t mk_exp(input logic [31:0] pc, input logic [31:0] instr,
                                 input logic [31:0] alu, input logic [31:0] mem_d,
                                 input logic [5:0] flags);
    wb_t e;
    e.pc = pc; e.instr = instr; e.alu = alu; e.mem_d = mem_d;
    e.mem_addr = alu; e.flags = flags;
    return e;
  endfunction

  function automatic wb_t obs();
    wb_t o;
    o.pc = wb_pc_o; o.instr = wb_instruction_o; o.alu = wb_alu_d_o;
    o.mem_d = wb_mem_d_o; o.mem_addr = wb_mem_addr_o;
    o.flags = {wb_ill, wb_imis, wb_ldmis, wb_stmis, wb_ldflt, wb_stflt};
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic k, input logic [31:0] pc,
                       input logic [31:0] instr, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic ill, input logic imis);
    valid_i = v; kill_i = k; pc_i = pc; instr_i = instr;
    alu_i = alu; rs2_i = rs2; e_ill = ill; e_imis = imis;
  endtask

  // Runs one bus transaction from the IDLE cycle where the request was just driven.
  task automatic drive_bus(input int waits, input logic [31:0] rdata, input bit ack_en,
                           output int stall_n, output int cyc_n,
                           output logic [31:0] addr, output logic [31:0] dat,
                           output logic [3:0] sel, output logic we);
    stall_n = 0; cyc_n = 0; addr = '0; dat = '0; sel = '0; we = 1'b0;
    #1;
    if (stall_o) stall_n++;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (!dwbm_cyc_o) break;
      cyc_n++;
      if (cyc_n == 1) begin
        addr = dwbm_addr_o; dat = dwbm_dat_o; sel = dwbm_sel_o; we = dwbm_we_o;
      end
      dwbm_ack_i = 1'b0;
      if (ack_en && cyc_n == waits + 1) begin
        dwbm_ack_i = 1'b1;
        dwbm_dat_i = rdata;
      end
      #1;
      if (stall_o) stall_n++;
    end
    dwbm_ack_i = 1'b0;
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    wb_t e;
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    dwbm_ack_i = 1'b0; dwbm_dat_i = '0;
    repeat (2) tick();
    e = mk_exp('0, NOP, '0, '0, 6'b0);
    checks++;
    if (obs() !== e) begin
      failures++; $display("FAIL reset_wb: got %h exp %h", obs(), e);
    end
    checks++;
    if ({wb_valid_o, stall_o} !== 2'b00) begin
      failures++; $display("FAIL reset_valid_stall: got %b exp 00", {wb_valid_o, stall_o});
    end
    checks++;
    if ({dwbm_cyc_o, dwbm_stb_o, dwbm_we_o, dwbm_sel_o, dwbm_addr_o, dwbm_dat_o} !== 71'h0) begin
      failures++; $display("FAIL reset_bus: cyc=%b stb=%b we=%b sel=%h addr=%h dat=%h exp all 0",
                           dwbm_cyc_o, dwbm_stb_o, dwbm_we_o, dwbm_sel_o, dwbm_addr_o, dwbm_dat_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lw_wait();
    int sn, cn; logic [31:0] a, d; logic [3:0] s; logic w; wb_t e;
    drive(1'b1, 1'b0, 32'h1000, mk(OP_LOAD, 3'b010), 32'h100, 32'h0, 1'b0, 1'b0);
    exp_q.push_back(mk_exp(32'h1000, mk(OP_LOAD, 3'b010), 32'h100, 32'hDEADBEEF, 6'b0));
    drive_bus(3, 32'hDEADBEEF, 1'b1, sn, cn, a, d, s, w);
    checks++;
    if (sn != 4) begin failures++; $display("FAIL lw_stall_cycles: got %0d exp 4", sn); end
    checks++;
    if ({a, s, w} !== {32'h100, 4'b1111, 1'b0}) begin
      failures++; $display("FAIL lw_bus: addr=%h sel=%b we=%b exp 100/1111/0", a, s, w);
    end
    checks++;
    if (wb_valid_o !== 1'b1 || exp_q.size() == 0) begin
      failures++; $display("FAIL lw_wb_valid: got %b exp 1", wb_valid_o);
    end else begin
      e = exp_q.pop_front();
      if (obs() !== e) begin failures++; $display("FAIL lw_wb: got %h exp %h", obs(), e); end
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3 [7]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010, 3'b011};
    logic [31:0] ad [7]  = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100, 32'h104, 32'h108};
    logic [31:0] rd [7]  = '{32'h80FFFF01, 32'h80FFFF01, 32'h80FFFF01, 32'h80FFFF01,
                             32'h80FFFF01, 32'h12345678, 32'hCAFEF00D};
    logic [31:0] ex [7]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h0000FF01,
                             32'h00000001, 32'h12345678, 32'h00000000};
    int sn, cn; logic [31:0] a, d; logic [3:0] s; logic w; wb_t e;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 32'h2000 + 32'(i * 4), mk(OP_LOAD, f3[i]), ad[i], 32'h0, 1'b0, 1'b0);
      exp_q.push_back(mk_exp(32'h2000 + 32'(i * 4), mk(OP_LOAD, f3[i]), ad[i], ex[i], 6'b0));
      drive_bus(0, rd[i], 1'b1, sn, cn, a, d, s, w);
      checks++;
      if (cn != 1 || s !== 4'b1111) begin
        failures++; $display("FAIL load%0d_bus: cyc_cycles=%0d sel=%b exp 1/1111", i, cn, s);
      end
      checks++;
      if (wb_valid_o !== 1'b1 || exp_q.size() == 0) begin
        failures++; $display("FAIL load%0d_valid: got %b exp 1", i, wb_valid_o);
      end else begin
        e = exp_q.pop_front();
        if (obs() !== e) begin failures++; $display("FAIL load%0d_wb: got %h exp %h", i, obs(), e); end
      end
    end
  endtask

  task automatic test_store_lanes();
    logic [2:0]  f3 [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] ad [3] = '{32'h202, 32'h201, 32'h300};
    logic [31:0] r2 [3] = '{32'h1234ABCD, 32'h000000A5, 32'h87654321};
    logic [31:0] xd [3] = '{32'hABCDABCD, 32'hA5A5A5A5, 32'h87654321};
    logic [3:0]  xs [3] = '{4'b1100, 4'b0010, 4'b1111};
    int sn, cn; logic [31:0] a, d; logic [3:0] s; logic w; wb_t e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h3000 + 32'(i * 4), mk(OP_STORE, f3[i]), ad[i], r2[i], 1'b0, 1'b0);
      exp_q.push_back(mk_exp(32'h3000 + 32'(i * 4), mk(OP_STORE, f3[i]), ad[i], 32'h0, 6'b0));
      drive_bus(1, 32'hFFFFFFFF, 1'b1, sn, cn, a, d, s, w);
      checks++;
      if ({a, d, s, w} !== {ad[i] & 32'hFFFFFFFC, xd[i], xs[i], 1'b1}) begin
        failures++; $display("FAIL store%0d_bus: addr=%h dat=%h sel=%b we=%b exp %h/%h/%b/1",
                             i, a, d, s, w, ad[i] & 32'hFFFFFFFC, xd[i], xs[i]);
      end
      checks++;
      if (wb_valid_o !== 1'b1 || exp_q.size() == 0) begin
        failures++; $display("FAIL store%0d_valid: got %b exp 1", i, wb_valid_o);
      end else begin
        e = exp_q.pop_front();
        if (obs() !== e) begin failures++; $display("FAIL store%0d_wb: got %h exp %h", i, obs(), e); end
      end
    end
  endtask

  task automatic test_misaligned();
    logic [6:0]  op [2] = '{OP_LOAD, OP_STORE};
    logic [2:0]  f3 [2] = '{3'b010, 3'b001};
    logic [31:0] ad [2] = '{32'h101, 32'h203};
    logic [5:0]  fl [2] = '{6'b001000, 6'b000100};
    wb_t e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'h4000, mk(op[i], f3[i]), ad[i], 32'h5555, 1'b0, 1'b0);
      exp_q.push_back(mk_exp(32'h4000, mk(op[i], f3[i]), ad[i], 32'h0, fl[i]));
      #1;
      checks++;
      if (stall_o !== 1'b0) begin failures++; $display("FAIL mis%0d_stall: got %b exp 0", i, stall_o); end
      tick();
      valid_i = 1'b0;
      checks++;
      if (dwbm_cyc_o !== 1'b0) begin failures++; $display("FAIL mis%0d_cyc: got %b exp 0", i, dwbm_cyc_o); end
      checks++;
      if (wb_valid_o !== 1'b1 || exp_q.size() == 0) begin
        failures++; $display("FAIL mis%0d_valid: got %b exp 1", i, wb_valid_o);
      end else begin
        e = exp_q.pop_front();
        if (obs() !== e) begin failures++; $display("FAIL mis%0d_wb: got %h exp %h", i, obs(), e); end
      end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] op [2] = '{OP_STORE, OP_LOAD};
    logic [5:0] fl [2] = '{6'b000001, 6'b000010};
    int sn, cn; logic [31:0] a, d; logic [3:0] s; logic w; wb_t e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'h5000, mk(op[i], 3'b010), 32'h400, 32'h11223344, 1'b0, 1'b0);
      exp_q.push_back(mk_exp(32'h5000, mk(op[i], 3'b010), 32'h400, 32'h0, fl[i]));
      drive_bus(0, 32'h0, 1'b0, sn, cn, a, d, s, w);
      checks++;
      if (cn != 4 || sn != 4) begin
        failures++; $display("FAIL timeout%0d_cycles: cyc=%0d stall=%0d exp 4/4", i, cn, sn);
      end
      checks++;
      if (wb_valid_o !== 1'b1 || exp_q.size() == 0) begin
        failures++; $display("FAIL timeout%0d_valid: got %b exp 1", i, wb_valid_o);
      end else begin
        e = exp_q.pop_front();
        if (obs() !== e) begin failures++; $display("FAIL timeout%0d_wb: got %h exp %h", i, obs(), e); end
      end
    end
  endtask

  task automatic test_upstream_flag();
    wb_t e;
    drive(1'b1, 1'b0, 32'h6000, mk(OP_LOAD, 3'b010), 32'h500, 32'h0, 1'b1, 1'b0);
    exp_q.push_back(mk_exp(32'h6000, mk(OP_LOAD, 3'b010), 32'h500, 32'h0, 6'b100000));
    #1;
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("FAIL upflag_stall: got %b exp 0", stall_o); end
    tick();
    valid_i = 1'b0; e_ill = 1'b0;
    checks++;
    if (dwbm_cyc_o !== 1'b0 || wb_valid_o !== 1'b1 || exp_q.size() == 0) begin
      failures++; $display("FAIL upflag_valid: cyc=%b valid=%b exp 0/1", dwbm_cyc_o, wb_valid_o);
    end else begin
      e = exp_q.pop_front();
      if (obs() !== e) begin failures++; $display("FAIL upflag_wb: got %h exp %h", obs(), e); end
    end
  endtask

  task automatic test_reset_mid_cycle();
    drive(1'b1, 1'b0, 32'h7000, mk(OP_LOAD, 3'b010), 32'h600, 32'h0, 1'b0, 1'b0);
    tick();
    checks++;
    if (dwbm_cyc_o !== 1'b1) begin failures++; $display("FAIL rstmid_pre_cyc: got %b exp 1", dwbm_cyc_o); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({dwbm_cyc_o, dwbm_stb_o, wb_valid_o} !== 3'b000 || wb_instruction_o !== NOP) begin
      failures++; $display("FAIL rstmid_drop: cyc=%b stb=%b valid=%b instr=%h exp 0/0/0/%h",
                           dwbm_cyc_o, dwbm_stb_o, wb_valid_o, wb_instruction_o, NOP);
    end
    valid_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    wb_t e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h8000 + 32'(i * 4), mk(OP_IMM, 3'b000), 32'h10 + 32'(i), 32'h0, 1'b0, 1'b0);
      exp_q.push_back(mk_exp(32'h8000 + 32'(i * 4), mk(OP_IMM, 3'b000), 32'h10 + 32'(i), 32'h0, 6'b0));
      #1;
      checks++;
      if (stall_o !== 1'b0) begin failures++; $display("FAIL b2b%0d_stall: got %b exp 0", i, stall_o); end
      tick();
      checks++;
      if (wb_valid_o !== 1'b1 || exp_q.size() == 0) begin
        failures++; $display("FAIL b2b%0d_valid: got %b exp 1", i, wb_valid_o);
      end else begin
        e = exp_q.pop_front();
        if (obs() !== e) begin failures++; $display("FAIL b2b%0d_wb: got %h exp %h", i, obs(), e); end
      end
    end
    drive(1'b1, 1'b1, 32'h800C, mk(OP_LOAD, 3'b010), 32'h100, 32'h0, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("FAIL kill_stall: got %b exp 0", stall_o); end
    tick();
    checks++;
    if ({dwbm_cyc_o, wb_valid_o} !== 2'b00 || wb_instruction_o !== NOP ||
        obs().flags !== 6'b0) begin
      failures++; $display("FAIL kill_wb: cyc=%b valid=%b instr=%h flags=%b exp 0/0/%h/0",
                           dwbm_cyc_o, wb_valid_o, wb_instruction_o, obs().flags, NOP);
    end
    valid_i = 1'b0; kill_i = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw_wait();
    test_load_extend();
    test_store_lanes();
    test_misaligned();
    test_timeout();
    test_upstream_flag();
    test_reset_mid_cycle();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: %0d entries left exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
Memory-access stage of the 5-stage RV32I pipeline, between execute and write-back. It performs data-memory loads and stores over a Wishbone-style master port, with byte-lane alignment, sign/zero extension, misalignment detection and bus-timeout faults. It stalls upstream while a bus cycle is outstanding and presents one registered instruction per cycle to write-back: data, address and exception flags.

Parameters:
BUS_TIMEOUT, 255, cycles to wait for dwbm_ack_i before aborting; 0 disables the timeout.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
valid_i  in  1  execute stage presents an instruction
kill_i  in  1  flush the instruction currently at the inputs
pc_i  in  32  instruction PC
instruction_i  in  32  raw instruction
alu_d_i  in  32  ALU result, or effective address for LOAD/STORE
rs2_d_i  in  32  store data
e_illegal_inst_i  in  1  upstream illegal-instruction flag
e_inst_addr_mis_i  in  1  upstream fetch-misaligned flag
stall_o  out  1  hold execute-stage outputs stable
dwbm_addr_o  out  32  word address, bits [1:0] = 0
dwbm_dat_o  out  32  store data, lane-replicated
dwbm_sel_o  out  4  byte enables
dwbm_we_o  out  1  write cycle
dwbm_cyc_o  out  1  bus cycle
dwbm_stb_o  out  1  strobe
dwbm_dat_i  in  32  read data
dwbm_ack_i  in  1  bus acknowledge
wb_valid_o  out  1  write-back inputs are valid
wb_pc_o  out  32  registered pc
wb_instruction_o  out  32  registered instruction; 32'h00000013 (NOP) when invalid
wb_alu_d_o  out  32  registered ALU result
wb_mem_d_o  out  32  extended load data
wb_mem_addr_o  out  32  full byte address (alu_d_i)
wb_e_illegal_inst_o  out  1  forwarded upstream flag
wb_e_inst_addr_mis_o  out  1  forwarded upstream flag
wb_e_ld_addr_mis_o  out  1  load address misaligned
wb_e_st_addr_mis_o  out  1  store address misaligned
wb_e_ld_fault_o  out  1  load bus timeout
wb_e_st_fault_o  out  1  store bus timeout

Behaviour:
- Reset (async): state IDLE, timeout counter 0, every output 0 except wb_instruction_o = NOP. Reset mid-cycle drops cyc/stb immediately.
- Decode: opcode = instruction_i[6:0], funct3 = instruction_i[14:12]. LOAD = 0000011, STORE = 0100011.
- Misalignment: half-word when addr[0] = 1; word when addr[1:0] != 0.
- mem_req = valid_i & !kill_i & (LOAD|STORE) & aligned & !e_illegal_inst_i & !e_inst_addr_mis_i.
- FSM IDLE:
  - mem_req: register bus outputs (cyc = stb = 1, we = STORE), go to BUS, load timeout counter. stall_o = 1 combinationally. wb_valid_o <= 0.
  - Otherwise: latch inputs into the wb_* registers in one cycle, with wb_valid_o <= valid_i & !kill_i. Misaligned LOAD/STORE sets the matching mis flag and issues no bus access.
  - Kill: wb_valid_o <= 0, wb_instruction_o <= NOP, all flags 0.
- FSM BUS:
  - stall_o = !(dwbm_ack_i | timeout). kill_i is ignored because the transaction is already committed.
  - ack: drop cyc/stb, latch wb_* from the held inputs plus extracted read data, wb_valid_o <= 1, go to IDLE. The next instruction is accepted the following cycle.
  - Timeout (counter reaches 0, BUS_TIMEOUT != 0): drop cyc/stb, raise wb_e_ld_fault_o or wb_e_st_fault_o, wb_valid_o <= 1, go to IDLE. An ack in the same cycle wins over the timeout.
- Store lanes:
  - SB: data = {4{rs2[7:0]}}, sel = 0001 << addr[1:0].
  - SH: data = {2{rs2[15:0]}}, sel = 0011 (addr[1] = 0) or 1100.
  - SW: data = rs2, sel = 1111.
  - Loads: sel = 1111.
- Load extract: byte/half selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. Undefined funct3 (011, 110, 111): mem_d = 0.
- For stores, wb_mem_d_o = 0.
- Latency: non-memory instruction 1 cycle. Memory op 1 + N cycles, where N = cycles until ack (minimum total 2).
- Upstream must hold its inputs stable while stall_o = 1.

Test Plan:
- LW at 0x100, ack after 3 wait cycles with dat 0xDEADBEEF -> stall_o high for 4 cycles, dwbm_addr_o = 0x100, sel = 1111; then wb_mem_d_o = 0xDEADBEEF, wb_valid_o = 1.
- LB at 0x103 with dat 0x80FF_FF01 -> wb_mem_d_o = 0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH at 0x202, rs2 = 0x1234ABCD -> dwbm_dat_o = 0xABCDABCD, sel = 1100, we = 1; wb_valid_o = 1 after ack.
- LW at 0x101 -> no cyc, stall_o = 0, wb_e_ld_addr_mis_o = 1, wb_mem_addr_o = 0x101 next cycle.
- Store with BUS_TIMEOUT = 4 and no ack -> cyc drops after 4 cycles, wb_e_st_fault_o = 1.
- Back-to-back ADDIs, then LW with kill_i = 1 in IDLE -> ADDI results stream with 1-cycle latency; the killed LW generates no bus cycle and wb_valid_o = 0.
